poly1305_mac: RTL and testbench
===============================

# poly1305_mac

Iterative Poly1305 one-time-authenticator engine that consumes 16-byte message blocks (AAD, ciphertext, length block) produced around the ChaCha20 datapath and emits the 128-bit tag. It sits downstream of the ChaCha20 keygen/encrypt stage inside the AEAD top level.
- Loads r/s from the ChaCha20-derived one-time key.
- Absorbs one block per `next` handshake using a multi-cycle multiply/reduce.
- Finalizes `tag = (acc + s) mod 2^128`.

## Interface
Parameters: none.

Ports (name, direction, width, meaning):
- `clk`  in  1  clock.
- `reset_n`  in  1  reset, synchronous, active-low.
- `init`  in  1  load key, clear accumulator; sampled only when `ready=1`.
- `next`  in  1  absorb `block`; sampled only when `ready=1`.
- `finalize`  in  1  compute tag; sampled only when `ready=1`.
- `key`  in  256  `[255:128]` r (unclamped, little-endian integer); `[127:0]` s (little-endian integer).
- `block`  in  128  message block as a little-endian integer (byte 0 = bits 7:0).
- `block_len`  in  5  valid bytes, 1..16; 0 or >16 is treated as 16.
- `ready`  out  1  idle, accepts a command.
- `tag_valid`  out  1  `tag` holds the final result.
- `tag`  out  128  Poly1305 tag, little-endian integer.

## Operation
- Registers:
  - `r_reg` [127:0]: `key[255:128] & R_CLAMP`.
  - `s_reg` [127:0].
  - `acc_reg` [129:0]: always fully reduced, < p, where p = 2^130-5.
  - `prod_reg` [261:0].
  - `mctr` [1:0].
  - `keyed` flag.
  - FSM state.
- Command priority when `ready=1`: `init` > `next` > `finalize`. All commands are ignored when `ready=0`.
- `init`:
  - Load `r_reg` and `s_reg`; clear `acc_reg`, `tag`, `tag_valid`; set `keyed`.
  - Single cycle; `ready` stays 1.
- `next`: ignored if `keyed=0` or `tag_valid=1`.
  - Message value m = (block masked to `block_len` bytes) + 2^(8·`block_len`).
  - FSM sequence:
    - ADD: h = `acc_reg` + m (131 bit).
    - MUL0..MUL3: `prod_reg` += h · r[32i+31:32i] << 32i, i = `mctr`.
    - RED1: x = prod[129:0] + 5·(prod>>130).
    - RED2: fold again, then subtract p if x ≥ p.
    - Write `acc_reg`; return to IDLE.
- `finalize`: ignored if `keyed=0` or `tag_valid=1`.
  - FIN: `tag <= (acc_reg + s_reg) mod 2^128`; `tag_valid <= 1`.
  - `tag_valid` holds until the next `init` or reset; further `next`/`finalize` are ignored until then.
- Reset values: `ready=1`, `tag_valid=0`, `tag=0`.
  - All registers are cleared; state is IDLE, `keyed=0`.
  - Reset mid-operation aborts immediately; no partial update survives.

## Timing
- FSM states: IDLE, ADD, MUL (4 cycles via `mctr`), RED1, RED2, FIN.
- `next` accepted at edge T:
  - `ready=0` for cycles T+1..T+7.
  - `acc_reg` updated at edge T+7.
  - `ready=1` at T+8.
  - Back-to-back blocks are possible every 8 cycles.
- `finalize` accepted at edge T:
  - `ready=0` during T+1.
  - `tag` and `tag_valid=1` visible from T+2; `ready=1` at T+2.
- `init` takes effect at the accepting edge, with no busy cycles.
- Inputs `block`/`block_len`/`key` are sampled only at the accepting edge. The block registers m internally, so upstream may change the inputs afterward.

## Structure
- The shared package/header `poly1305_defs` holds:
  - `R_CLAMP` = 128'h0ffffffc0ffffffc0ffffffc0fffffff.
  - `POLY1305` = 130'h3fffffffffffffffffffffffffffffffb.
  - FSM state encodings.
- Sub-module `poly1305_mulacc`: combinational 131×32 partial product plus 262-bit accumulate. It is instantiated once and time-multiplexed over `mctr`.
- Byte-order conversion from wire format to little-endian integers is done upstream and is not part of this block.

## Test plan
- RFC 8439 §2.5.2 vector:
  - Stimulus: r=0xa806d542fe52447f336d555778bed685, s=0x1bf54941aff6bf4afdb20dfb8a800301. Message "Cryptographic Forum Research Group" as blocks of 16, 16 and 2 bytes, then `finalize`.
  - Required: `tag`=0xa927010caf8b2bc2c6365130c11d06a8. `ready` is low exactly 7 cycles per block.
- Reduction wrap:
  - Stimulus: r=1, s=0; two blocks of 0xffff…ff with `block_len`=16.
  - Required: after block 1 the tag would be 0xffffffffffffffffffffffffffffffff. After block 2 plus `finalize`, `tag`=0x3.
- Padding and `block_len`:
  - Stimulus: r=1, s=0, one block with `block_len`=1 and `block`=0xffff…ff00.
  - Required: `tag`=0x100. The same block with `block_len`=0 is treated as 16.
- r=0, s=0x0123456789abcdef0011223344556677, any three blocks → `tag`=s.
- Command gating:
  - `next`/`finalize` before any `init` → ignored, `ready` stays 1.
  - `next` pulsed while busy → ignored; the result equals the single-block result.
  - `init`+`next` in the same cycle → only `init` acts.
- Reset mid-MUL:
  - Stimulus: assert `reset_n`=0 for one cycle.
  - Required: next cycle `ready=1`, `tag_valid=0`, `tag=0`. A subsequent full RFC vector still yields the correct tag.

Source files
------------

// File: rtl/poly1305_defs.sv
// Shared constants, FSM encoding and message padding helper for the Poly1305 engine.
package poly1305_defs;

    localparam logic [127:0] R_CLAMP  = 128'h0ffffffc0ffffffc0ffffffc0fffffff;
    localparam logic [129:0] POLY1305 = 130'h3fffffffffffffffffffffffffffffffb;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADD  = 3'd1,
        ST_MUL  = 3'd2,
        ST_RED1 = 3'd3,
        ST_RED2 = 3'd4,
        ST_FIN  = 3'd5
    } state_t;

    // Keep the first len bytes and append the 0x01 marker byte just above them.
    function automatic logic [128:0] pad_block(input logic [127:0] blk, input logic [4:0] len);
        logic [4:0]   n;
        logic [128:0] m;
        n = (len == 5'd0 || len > 5'd16) ? 5'd16 : len;
        m = '0;
        for (int i = 0; i < 16; i++) begin
            if (i < int'(n)) begin
                m[8*i +: 8] = blk[8*i +: 8];
            end
        end
        m[{n, 3'b000}] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/poly1305_mulacc.sv
// One 131x32 partial product of h*r, shifted into place and added to the running product.
module poly1305_mulacc (
    input  logic [130:0] h,
    input  logic [31:0]  r_limb,
    input  logic [1:0]   idx,
    input  logic [261:0] acc_in,
    output logic [261:0] acc_out
);

    logic [162:0] pp;

    assign pp      = {32'b0, h} * {131'b0, r_limb};
    assign acc_out = acc_in + ({99'b0, pp} << {idx, 5'b00000});

endmodule

// File: rtl/poly1305_mac.sv
// Iterative Poly1305 authenticator: one 16-byte block per 8 cycles, tag = (acc + s) mod 2^128.
module poly1305_mac
    import poly1305_defs::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         init,
    input  logic         next,
    input  logic         finalize,
    input  logic [255:0] key,
    input  logic [127:0] block,
    input  logic [4:0]   block_len,
    output logic         ready,
    output logic         tag_valid,
    output logic [127:0] tag
);

    // Handshake: a command (init > next > finalize) is taken at a rising edge where
    // ready=1 and the command is high; key/block/block_len are captured at that same
    // edge only. While ready=0 every command input is ignored, never queued.

    state_t       state;
    logic [1:0]   mctr;
    logic         keyed;
    logic [127:0] r_reg;
    logic [127:0] s_reg;
    logic [129:0] acc_reg;
    logic [128:0] m_reg;
    logic [130:0] h_reg;
    logic [261:0] prod_reg;

    logic [261:0] mul_out;
    logic [261:0] fold;
    logic [130:0] y;
    logic [129:0] acc_next;

    poly1305_mulacc u_mulacc (
        .h       (h_reg),
        .r_limb  (r_reg[{mctr, 5'b00000} +: 32]),
        .idx     (mctr),
        .acc_in  (prod_reg),
        .acc_out (mul_out)
    );

    // 2^130 == 5 (mod p): fold the high part back in; applied twice, then one conditional subtract.
    assign fold     = {132'b0, prod_reg[129:0]} + ({130'b0, prod_reg[261:130]} * 262'd5);
    assign y        = fold[130:0];
    assign acc_next = (y >= {1'b0, POLY1305}) ? 130'(y - {1'b0, POLY1305}) : y[129:0];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            mctr      <= 2'd0;
            keyed     <= 1'b0;
            r_reg     <= '0;
            s_reg     <= '0;
            acc_reg   <= '0;
            m_reg     <= '0;
            h_reg     <= '0;
            prod_reg  <= '0;
            ready     <= 1'b1;
            tag_valid <= 1'b0;
            tag       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (init) begin
                        r_reg     <= key[255:128] & R_CLAMP;
                        s_reg     <= key[127:0];
                        acc_reg   <= '0;
                        tag       <= '0;
                        tag_valid <= 1'b0;
                        keyed     <= 1'b1;
                    end else if (next && keyed && !tag_valid) begin
                        m_reg <= pad_block(block, block_len);
                        state <= ST_ADD;
                        ready <= 1'b0;
                    end else if (finalize && keyed && !tag_valid) begin
                        state <= ST_FIN;
                        ready <= 1'b0;
                    end
                end
                ST_ADD: begin
                    h_reg    <= {1'b0, acc_reg} + {2'b0, m_reg};
                    prod_reg <= '0;
                    mctr     <= 2'd0;
                    state    <= ST_MUL;
                end
                ST_MUL: begin
                    prod_reg <= mul_out;
                    mctr     <= mctr + 2'd1;
                    if (mctr == 2'd3) begin
                        state <= ST_RED1;
                    end
                end
                ST_RED1: begin
                    prod_reg <= fold;
                    state    <= ST_RED2;
                end
                ST_RED2: begin
                    acc_reg <= acc_next;
                    state   <= ST_IDLE;
                    ready   <= 1'b1;
                end
                ST_FIN: begin
                    tag       <= acc_reg[127:0] + s_reg;
                    tag_valid <= 1'b1;
                    state     <= ST_IDLE;
                    ready     <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_poly1305_mac.sv
// Self-checking bench for poly1305_mac: known vectors, random messages against a modular-arithmetic model, gating and reset corners.
module tb_poly1305_mac;

    localparam logic [127:0] CLAMP = 128'h0ffffffc0ffffffc0ffffffc0fffffff;
    localparam logic [129:0] P     = 130'h3fffffffffffffffffffffffffffffffb;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         init = 1'b0;
    logic         next = 1'b0;
    logic         finalize = 1'b0;
    logic [255:0] key = '0;
    logic [127:0] block = '0;
    logic [4:0]   block_len = 5'd0;
    logic         ready;
    logic         tag_valid;
    logic [127:0] tag;

    int total = 0;
    int bad   = 0;
    logic [127:0] exp_q[$];

    typedef struct {
        logic [127:0]       r;
        logic [127:0]       s;
        int                 nblk;
        logic [2:0][127:0]  blk;
        logic [2:0][4:0]    len;
        logic [127:0]       exp_tag;
    } vec_t;

    vec_t vecs[5];

    poly1305_mac dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .init      (init),
        .next      (next),
        .finalize  (finalize),
        .key       (key),
        .block     (block),
        .block_len (block_len),
        .ready     (ready),
        .tag_valid (tag_valid),
        .tag       (tag)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [129:0] model_absorb(input logic [129:0] acc, input logic [127:0] r,
                                                  input logic [127:0] blk, input logic [4:0] len);
        int           n;
        logic [261:0] pw;
        logic [261:0] m;
        logic [261:0] t;
        n  = (len == 5'd0 || len > 5'd16) ? 16 : int'(len);
        pw = 262'd1 << (8 * n);
        m  = ({134'd0, blk} & (pw - 262'd1)) + pw;
        t  = (({132'd0, acc} + m) * {134'd0, r & CLAMP}) % {132'd0, P};
        return t[129:0];
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_tag(input string name);
        logic [127:0] e;
        check({name, "_valid"}, 128'(tag_valid), 128'd1);
        if (exp_q.size() == 0) begin
            check({name, "_queue"}, 128'd0, 128'd1);
        end else begin
            e = exp_q.pop_front();
            check(name, tag, e);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic wait_ready(output int cycles);
        cycles = 0;
        while (ready !== 1'b1 && cycles < 50) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic do_init(input logic [127:0] r, input logic [127:0] s);
        @(negedge clk);
        key  = {r, s};
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        key  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic do_next(input logic [127:0] blk, input logic [4:0] len, output int busy);
        @(negedge clk);
        block     = blk;
        block_len = len;
        next      = 1'b1;
        @(negedge clk);
        next      = 1'b0;
        block     = {$urandom, $urandom, $urandom, $urandom};
        block_len = 5'($urandom_range(0, 31));
        wait_ready(busy);
    endtask

    task automatic do_finalize(output int busy);
        @(negedge clk);
        finalize = 1'b1;
        @(negedge clk);
        finalize = 1'b0;
        wait_ready(busy);
    endtask

    task automatic run_msg(input string name, input logic [127:0] r, input logic [127:0] s,
                           input int nblk, input logic [2:0][127:0] blk, input logic [2:0][4:0] len,
                           input logic [127:0] exp_tag);
        int busy;
        exp_q.push_back(exp_tag);
        do_init(r, s);
        for (int i = 0; i < nblk; i++) begin
            do_next(blk[i], len[i], busy);
            check($sformatf("%s_busy%0d", name, i), 128'(busy), 128'd7);
        end
        do_finalize(busy);
        check({name, "_fin_busy"}, 128'(busy), 128'd1);
        check_tag(name);
    endtask

    // ---------------- test ----------------
    initial begin
        int           busy;
        logic [129:0] acc;
        logic [127:0] r;
        logic [127:0] s;
        logic [127:0] b;
        logic [4:0]   l;
        logic [127:0] saved;
        int           nb;

        vecs[0].r = 128'ha806d542fe52447f336d555778bed685;
        vecs[0].s = 128'h1bf54941aff6bf4afdb20dfb8a800301;
        vecs[0].nblk = 3;
        vecs[0].blk = {128'h7075, 128'h6f7247206863726165736552206d7572, 128'h6f4620636968706172676f7470797243};
        vecs[0].len = {5'd2, 5'd16, 5'd16};
        vecs[0].exp_tag = 128'ha927010caf8b2bc2c6365130c11d06a8;

        vecs[1].r = 128'd1;
        vecs[1].s = 128'd0;
        vecs[1].nblk = 1;
        vecs[1].blk = {128'd0, 128'd0, {128{1'b1}}};
        vecs[1].len = {5'd16, 5'd16, 5'd16};
        vecs[1].exp_tag = {128{1'b1}};

        vecs[2].r = 128'd1;
        vecs[2].s = 128'd0;
        vecs[2].nblk = 2;
        vecs[2].blk = {128'd0, {128{1'b1}}, {128{1'b1}}};
        vecs[2].len = {5'd16, 5'd16, 5'd16};
        vecs[2].exp_tag = 128'd3;

        vecs[3].r = 128'd1;
        vecs[3].s = 128'd0;
        vecs[3].nblk = 1;
        vecs[3].blk = {128'd0, 128'd0, 128'hffffffffffffffffffffffffffffff00};
        vecs[3].len = {5'd16, 5'd16, 5'd1};
        vecs[3].exp_tag = 128'h100;

        vecs[4].r = 128'd0;
        vecs[4].s = 128'h0123456789abcdef0011223344556677;
        vecs[4].nblk = 3;
        vecs[4].blk = {128'hdeadbeef, 128'h1234_5678_9abc_def0, {128{1'b1}}};
        vecs[4].len = {5'd3, 5'd0, 5'd16};
        vecs[4].exp_tag = 128'h0123456789abcdef0011223344556677;

        // reset
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("reset_ready", 128'(ready), 128'd1);
        check("reset_tag_valid", 128'(tag_valid), 128'd0);
        check("reset_tag", tag, 128'd0);

        // commands before any init are ignored
        next = 1'b1; block = {128{1'b1}}; block_len = 5'd16;
        @(negedge clk);
        next = 1'b0;
        check("unkeyed_next_ready", 128'(ready), 128'd1);
        finalize = 1'b1;
        @(negedge clk);
        finalize = 1'b0;
        check("unkeyed_fin_ready", 128'(ready), 128'd1);
        @(negedge clk);
        check("unkeyed_fin_valid", 128'(tag_valid), 128'd0);

        // table-driven known vectors
        for (int v = 0; v < 5; v++) begin
            run_msg($sformatf("vec%0d", v), vecs[v].r, vecs[v].s, vecs[v].nblk,
                    vecs[v].blk, vecs[v].len, vecs[v].exp_tag);
        end

        // block_len=0 is treated as a full 16-byte block
        exp_q.push_back(128'hffffffffffffffffffffffffffffff00);
        do_init(128'd1, 128'd0);
        do_next(128'hffffffffffffffffffffffffffffff00, 5'd0, busy);
        do_finalize(busy);
        check_tag("len0_as_16");

        // after the tag is valid, next/finalize are ignored until init
        saved = tag;
        @(negedge clk);
        next = 1'b1; block = 128'h55; block_len = 5'd4;
        @(negedge clk);
        next = 1'b0;
        check("tagged_next_ready", 128'(ready), 128'd1);
        finalize = 1'b1;
        @(negedge clk);
        finalize = 1'b0;
        check("tagged_fin_ready", 128'(ready), 128'd1);
        @(negedge clk);
        check("tagged_tag_hold", tag, saved);

        // init and next together: only init acts
        do_init(128'd1, 128'd0);
        @(negedge clk);
        key = {128'd1, 128'hcafe_f00d}; init = 1'b1; next = 1'b1;
        block = {128{1'b1}}; block_len = 5'd16;
        @(negedge clk);
        init = 1'b0; next = 1'b0;
        check("init_next_ready", 128'(ready), 128'd1);
        exp_q.push_back(128'hcafe_f00d);
        do_finalize(busy);
        check_tag("init_next_tag");

        // next pulsed while busy is ignored
        r = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
        s = 128'h11111111_22222222_33333333_44444444;
        b = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
        exp_q.push_back(128'(model_absorb(130'd0, r, b, 5'd16) + {2'b0, s}));
        do_init(r, s);
        @(negedge clk);
        block = b; block_len = 5'd16; next = 1'b1;
        @(negedge clk);
        next = 1'b0;
        @(negedge clk);
        block = ~b; block_len = 5'd5; next = 1'b1;
        @(negedge clk);
        next = 1'b0;
        wait_ready(busy);
        check("busy_next_len", 128'(busy), 128'd5);
        @(negedge clk);
        check("busy_next_not_queued", 128'(ready), 128'd1);
        do_finalize(busy);
        check_tag("busy_next_tag");

        // randomized messages against the model
        for (int k = 0; k < 12; k++) begin
            r  = {$urandom, $urandom, $urandom, $urandom};
            s  = {$urandom, $urandom, $urandom, $urandom};
            nb = $urandom_range(1, 4);
            acc = '0;
            do_init(r, s);
            for (int i = 0; i < nb; i++) begin
                b = {$urandom, $urandom, $urandom, $urandom};
                l = 5'($urandom_range(0, 20));
                acc = model_absorb(acc, r, b, l);
                do_next(b, l, busy);
                check($sformatf("rand%0d_busy%0d", k, i), 128'(busy), 128'd7);
            end
            exp_q.push_back(acc[127:0] + s);
            do_finalize(busy);
            check_tag($sformatf("rand%0d", k));
        end

        // reset in the middle of the multiply
        do_init(vecs[0].r, vecs[0].s);
        @(negedge clk);
        block = vecs[0].blk[0]; block_len = 5'd16; next = 1'b1;
        @(negedge clk);
        next = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("midreset_ready", 128'(ready), 128'd1);
        check("midreset_tag_valid", 128'(tag_valid), 128'd0);
        check("midreset_tag", tag, 128'd0);
        finalize = 1'b1;
        @(negedge clk);
        finalize = 1'b0;
        check("midreset_unkeyed", 128'(ready), 128'd1);
        run_msg("rfc_after_reset", vecs[0].r, vecs[0].s, vecs[0].nblk,
                vecs[0].blk, vecs[0].len, vecs[0].exp_tag);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
